// File: rtl/occupancy_tracker_if.sv
// Handshake bundle between the direction FSM / display side and occupancy_tracker.
// master drives events and error clear; slave (the tracker) drives status and LEDs.
interface occupancy_tracker_if #(
  parameter int CNT_W = 3
);
  logic             s;
  logic             r;
  logic             err_clr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             err_ovf;
  logic             err_unf;
  logic [CNT_W-1:0] leds;

  modport master (
    output s, r, err_clr,
    input  count, full, empty, err_ovf, err_unf, leds
  );

  modport slave (
    input  s, r, err_clr,
    output count, full, empty, err_ovf, err_unf, leds
  );
endinterface

// File: rtl/occupancy_tracker.sv
// Parking-lot occupancy counter with edge-detected entry/exit events and sticky errors.
// Define FULL_BLINK_EN to blink the LED display while the lot is full.
module occupancy_tracker #(
  parameter int CAPACITY   = 7,
  parameter int CNT_W      = 3,
  parameter int BLINK_HALF = 6000000
) (
  input logic                 clk,
  input logic                 rst,
  occupancy_tracker_if.slave  bus
);

  if (CAPACITY < 1 || CAPACITY > (2**CNT_W) - 1 || BLINK_HALF < 1) begin : g_bad_param
    $error("occupancy_tracker: illegal CAPACITY/CNT_W/BLINK_HALF combination");
  end

  localparam logic [CNT_W-1:0] CAP_VAL = CNT_W'(CAPACITY);

  logic             s_prev_reg;
  logic             r_prev_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;
  logic             s_evt, r_evt;
  logic             full_w, empty_w;

  // Previous-value registers reset high so a level already present at release is not an event.
  assign s_evt   = bus.s & ~s_prev_reg;
  assign r_evt   = bus.r & ~r_prev_reg;
  assign full_w  = (count_reg == CAP_VAL);
  assign empty_w = (count_reg == '0);

  always_comb begin
    count_next = count_reg;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    if (bus.err_clr) begin
      ovf_next = 1'b0;
      unf_next = 1'b0;
    end
    // A new error is applied after the clear so a coincident set wins.
    if (s_evt && !r_evt) begin
      if (full_w) ovf_next   = 1'b1;
      else        count_next = count_reg + CNT_W'(1);
    end else if (r_evt && !s_evt) begin
      if (empty_w) unf_next   = 1'b1;
      else         count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev_reg <= 1'b1;
      r_prev_reg <= 1'b1;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      s_prev_reg <= bus.s;
      r_prev_reg <= bus.r;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
    end
  end

  assign bus.count   = count_reg;
  assign bus.full    = full_w;
  assign bus.empty   = empty_w;
  assign bus.err_ovf = ovf_reg;
  assign bus.err_unf = unf_reg;

`ifdef FULL_BLINK_EN
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               phase_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b1;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_reg <= '0;
      phase_reg     <= ~phase_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
    end
  end

  // Blank the display during the off phase only while the lot is full.
  for (genvar gi = 0; gi < CNT_W; gi++) begin : g_leds
    assign bus.leds[gi] = count_reg[gi] & (phase_reg | ~full_w);
  end
`else
  for (genvar gi = 0; gi < CNT_W; gi++) begin : g_leds
    assign bus.leds[gi] = count_reg[gi];
  end
`endif

endmodule

// File: tb/tb_occupancy_tracker.sv
// Directed self-checking bench for occupancy_tracker (CAPACITY 7, CNT_W 3, BLINK_HALF 4).
// Blink checks are compiled in only when FULL_BLINK_EN is defined.
module tb_occupancy_tracker;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  occupancy_tracker_if #(.CNT_W(3)) bus ();

  occupancy_tracker #(.CAPACITY(7), .CNT_W(3), .BLINK_HALF(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.s = 1'b0; bus.r = 1'b0; bus.err_clr = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic pulse_s();
    bus.s = 1'b1; tick(1);
    bus.s = 1'b0; tick(1);
  endtask

  task automatic pulse_r();
    bus.r = 1'b1; tick(1);
    bus.r = 1'b0; tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    vectors++; if (bus.leds !== 3'b000) begin miscompares++; $display("FAIL reset_leds: got %b expected 000", bus.leds); end
    vectors++; if ({bus.err_ovf, bus.err_unf} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b expected 00", {bus.err_ovf, bus.err_unf}); end
    $display("test_reset done");
  endtask

  task automatic test_count_up();
    do_reset();
    pulse_s();
    vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL first_entry: got %0d expected 1", bus.count); end
    pulse_s(); pulse_s();
    vectors++; if (bus.count !== 3'd3) begin miscompares++; $display("FAIL count3: got %0d expected 3", bus.count); end
    vectors++; if ({bus.empty, bus.full} !== 2'b00) begin miscompares++; $display("FAIL count3_empty_full: got %b expected 00", {bus.empty, bus.full}); end
    vectors++; if (bus.leds !== 3'b011) begin miscompares++; $display("FAIL count3_leds: got %b expected 011", bus.leds); end
    pulse_r();
    vectors++; if (bus.count !== 3'd2) begin miscompares++; $display("FAIL exit_dec: got %0d expected 2", bus.count); end
    $display("test_count_up done");
  endtask

  task automatic test_held_input();
    do_reset();
    bus.s = 1'b1;
    tick(1);
    vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL held_latency: got %0d expected 1", bus.count); end
    tick(49);
    bus.s = 1'b0;
    tick(1);
    vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL held_50: got %0d expected 1", bus.count); end
    $display("test_held_input done");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 7; i++) pulse_s();
    vectors++; if (bus.count !== 3'd7) begin miscompares++; $display("FAIL fill7: got %0d expected 7", bus.count); end
    vectors++; if ({bus.full, bus.empty, bus.err_ovf} !== 3'b100) begin miscompares++; $display("FAIL fill7_status: got %b expected 100", {bus.full, bus.empty, bus.err_ovf}); end
    pulse_s();
    vectors++; if (bus.count !== 3'd7) begin miscompares++; $display("FAIL ovf_saturate: got %0d expected 7", bus.count); end
    vectors++; if (bus.err_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b expected 1", bus.err_ovf); end
    tick(3);
    vectors++; if (bus.err_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b expected 1", bus.err_ovf); end
    bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
    vectors++; if (bus.err_ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b expected 0", bus.err_ovf); end
    vectors++; if (bus.count !== 3'd7) begin miscompares++; $display("FAIL ovf_clear_count: got %0d expected 7", bus.count); end
    $display("test_overflow done");
  endtask

  task automatic test_underflow();
    do_reset();
    pulse_r();
    vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL unf_hold: got %0d expected 0", bus.count); end
    vectors++; if (bus.err_unf !== 1'b1) begin miscompares++; $display("FAIL unf_flag: got %b expected 1", bus.err_unf); end
    bus.s = 1'b1; bus.r = 1'b1; tick(1);
    bus.s = 1'b0; bus.r = 1'b0; tick(1);
    vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL unf_both: got %0d expected 0", bus.count); end
    vectors++; if ({bus.err_unf, bus.err_ovf} !== 2'b10) begin miscompares++; $display("FAIL unf_both_flags: got %b expected 10", {bus.err_unf, bus.err_ovf}); end
    // Clear coinciding with a fresh underflow: the set must win.
    bus.r = 1'b1; bus.err_clr = 1'b1; tick(1);
    bus.r = 1'b0; bus.err_clr = 1'b0; tick(1);
    vectors++; if (bus.err_unf !== 1'b1) begin miscompares++; $display("FAIL set_wins: got %b expected 1", bus.err_unf); end
    bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
    vectors++; if (bus.err_unf !== 1'b0) begin miscompares++; $display("FAIL unf_clear: got %b expected 0", bus.err_unf); end
    $display("test_underflow done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) pulse_s();
    bus.s = 1'b1; bus.r = 1'b1; tick(1);
    bus.s = 1'b0; bus.r = 1'b0; tick(1);
    vectors++; if (bus.count !== 3'd4) begin miscompares++; $display("FAIL simul_events: got %0d expected 4", bus.count); end
    vectors++; if ({bus.err_ovf, bus.err_unf} !== 2'b00) begin miscompares++; $display("FAIL simul_flags: got %b expected 00", {bus.err_ovf, bus.err_unf}); end
    // Alternating single-cycle entries and exits with no gap between them.
    bus.s = 1'b1; tick(1); bus.s = 1'b0; bus.r = 1'b1; tick(1); bus.r = 1'b0; bus.s = 1'b1; tick(1); bus.s = 1'b0; tick(1);
    vectors++; if (bus.count !== 3'd5) begin miscompares++; $display("FAIL alternate: got %0d expected 5", bus.count); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) pulse_s();
    pulse_r(); pulse_r(); pulse_r(); pulse_r(); pulse_r();
    vectors++; if ({bus.count, bus.err_unf} !== 4'b0001) begin miscompares++; $display("FAIL pre_reset_state: got %b expected 0001", {bus.count, bus.err_unf}); end
    pulse_s(); pulse_s();
    bus.s = 1'b1; bus.err_clr = 1'b1; rst = 1'b1; tick(1);
    rst = 1'b0; bus.err_clr = 1'b0;
    vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL rst_mid_count: got %0d expected 0", bus.count); end
    vectors++; if ({bus.full, bus.empty, bus.leds, bus.err_ovf, bus.err_unf} !== 7'b0100000) begin miscompares++; $display("FAIL rst_mid_outputs: got %b expected 0100000", {bus.full, bus.empty, bus.leds, bus.err_ovf, bus.err_unf}); end
    tick(3);
    vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL held_through_reset: got %0d expected 0", bus.count); end
    bus.s = 1'b0; tick(1);
    pulse_s();
    vectors++; if (bus.count !== 3'd1) begin miscompares++; $display("FAIL post_reset_entry: got %0d expected 1", bus.count); end
    $display("test_reset_mid done");
  endtask

`ifdef FULL_BLINK_EN
  task automatic test_blink();
    logic [2:0] samp [0:19];
    int k;
    do_reset();
    for (int i = 0; i < 7; i++) pulse_s();
    for (int i = 0; i < 20; i++) begin samp[i] = bus.leds; tick(1); end
    k = 0;
    for (int i = 4; i >= 1; i--) if (samp[i] !== samp[0]) k = i;
    vectors++; if (k == 0) begin miscompares++; $display("FAIL blink_toggle: got no change in 5 cycles expected toggle"); end
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (samp[i] !== 3'b111 && samp[i] !== 3'b000) begin miscompares++; $display("FAIL blink_value[%0d]: got %b expected 111 or 000", i, samp[i]); end
    end
    if (k != 0) begin
      for (int i = k; i < k + 16; i++) begin
        vectors++;
        if (samp[i] !== ((((i - k) / 4) % 2 == 0) ? samp[k] : ~samp[k])) begin
          miscompares++; $display("FAIL blink_period[%0d]: got %b expected %b", i, samp[i], ((((i - k) / 4) % 2 == 0) ? samp[k] : ~samp[k]));
        end
      end
    end
    pulse_r();
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (bus.leds !== 3'b110) begin miscompares++; $display("FAIL steady_leds[%0d]: got %b expected 110", i, bus.leds); end
      tick(1);
    end
    $display("test_blink done");
  endtask
`else
  task automatic test_leds_full();
    do_reset();
    for (int i = 0; i < 7; i++) pulse_s();
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (bus.leds !== 3'b111) begin miscompares++; $display("FAIL leds_full[%0d]: got %b expected 111", i, bus.leds); end
      tick(1);
    end
    pulse_r();
    vectors++; if (bus.leds !== 3'b110) begin miscompares++; $display("FAIL leds_after_exit: got %b expected 110", bus.leds); end
    $display("test_leds_full done");
  endtask
`endif

  initial begin
    bus.s = 1'b0; bus.r = 1'b0; bus.err_clr = 1'b0; rst = 1'b1;
    test_reset();
    test_count_up();
    test_held_input();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
`ifdef FULL_BLINK_EN
    test_blink();
`else
    test_leds_full();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
